mioc_dram_ctrl: RTL and testbench
=================================

# mioc_dram_ctrl

DRAM access sequencer and bus arbiter for the MIOC top level. It turns buffered Z80 memory and refresh cycles into RAS_N/MUX/CAS1_N/CAS2_N strobes. It runs the BUSRQ_N/BUSAK_N handshake that hands the buffered bus to the 6801 DMA master. While the Z80 is off the bus and not refreshing, it inserts RAS-only refresh cycles from an internal row counter. It sits between the MIOC address decode and the DRAM control pins.

## Interface
Parameters:
- REF_INTERVAL, 56: B_PHI cycles between internal refreshes (128 rows / 2 ms at 3.58 MHz).
- PRECHARGE_CYC, 1: minimum RAS_N-high cycles after any RAS cycle.

Ports:
- B_PHI  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- BMREQ_N, BRD_N, N_BWR, BRFSH_N  in  1 each  buffered memory request / read / write / refresh, active-low.
- BA15  in  1  bank select: 0 → CAS1_N, 1 → CAS2_N.
- RAMSEL  in  1  decode says current address is DRAM.
- DMA_N  in  1  6801 DMA request, active-low.
- BUSAK_N  in  1  Z80 bus acknowledge, active-low.
- BUSRQ_N  out  1  Z80 bus request.
- ADDRBUFEN_N  out  1  Z80 address buffer enable; 1 = buffers off during DMA.
- RAS_N, CAS1_N, CAS2_N  out  1 each  DRAM strobes.
- MUX  out  1  0 = row address, 1 = column address.
- REFSEL  out  1  put REFROW on the RA bus.
- REFROW  out  7  internal refresh row.

## Operation
- All outputs are registered.
- Reset values: RAS_N=1, CAS1_N=1, CAS2_N=1, MUX=0, BUSRQ_N=1, ADDRBUFEN_N=0, REFSEL=0, REFROW=0. The refresh timer is cleared and both FSMs go to their first state.

Memory FSM states: IDLE, ROW, COL, CAS, PRE, RFSH, IREF.
- **IDLE → ROW** on access: BMREQ_N=0 & BRFSH_N=1 & RAMSEL=1 & (BRD_N=0 | N_BWR=0).
  - ROW captures BA15 into the bank register.
- **ROW → COL → CAS**: CAS stays while BMREQ_N=0.
  - BMREQ_N=1 → PRE.
- **IDLE → RFSH** on BMREQ_N=0 & BRFSH_N=0: RAS-only cycle.
  - RFSH holds while BMREQ_N=0, then goes to PRE.
  - Clears the refresh timer.
- **IDLE → IREF** when the refresh timer has expired and no access is pending.
  - IREF: RAS_N=0 for 2 cycles with REFSEL=1, then PRE.
  - REFROW increments (mod 128) on leaving IREF; timer cleared.
- **PRE** holds RAS_N=1 for PRECHARGE_CYC cycles, then → IDLE.
- **Priority at IDLE**: Z80 refresh > access > internal refresh. A pending internal refresh waits at most one access.
- **Mid-cycle request drop**: if BMREQ_N rises in ROW or COL, go to PRE directly; CAS is never asserted.

Bus FSM states: BZ80, BREQ, BDMA, BREL.
- **BZ80**: BUSRQ_N=1, ADDRBUFEN_N=0. DMA_N=0 → BREQ.
- **BREQ**: BUSRQ_N=0.
  - BUSAK_N=0 → BDMA.
  - DMA_N=1 before grant → BZ80.
- **BDMA**: BUSRQ_N=0, ADDRBUFEN_N=1. DMA_N=1 → BREL.
- **BREL**: BUSRQ_N=1, ADDRBUFEN_N=1.
  - BUSAK_N=1 and memory FSM in IDLE → BZ80.
  - Otherwise hold.
- Internal refresh runs in every bus state. In BZ80 it fires only if the Z80 misses refreshes for REF_INTERVAL cycles.

Reset mid-operation: every output returns to its reset value at the next edge. Precharge is not guaranteed across reset.

## Timing
- Request sampled at edge k:
  - RAS_N low at k+1 (MUX=0)
  - MUX=1 at k+2
  - selected CASx_N low at k+3
- BMREQ_N seen high at edge m: RAS_N, CASx_N high and MUX=0 at m+1; RAS_N stays high through m+PRECHARGE_CYC.
- Refresh timer: 7-bit down-counter loaded with REF_INTERVAL-1 and decremented each cycle. Expiry is a sticky pending flag, cleared when IREF or RFSH is entered.
- Bus handshake: one-cycle latency on each transition (DMA_N→BUSRQ_N, BUSAK_N→ADDRBUFEN_N).
- Bank register is stable from ROW until PRE. BA15 changes mid-cycle are ignored.
- CAS1_N and CAS2_N are never low together. CAS never goes low while RAS_N=1.

## Structure
- **mioc_pkg**:
  - memory and bus state enums
  - REF_INTERVAL and PRECHARGE_CYC defaults
  - REFROW width constant (7)
- **mioc_refresh_timer** sub-module:
  - interval down-counter, sticky pending flag, 7-bit row counter
  - inputs: clear, advance
  - outputs: pending, REFROW
- Top: two FSMs in one module.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with all requests active → all outputs at reset values, REFROW=0.
- Z80 read, BA15=0: BMREQ_N=BRD_N=0 at edge 0 → RAS_N↓ at 1, MUX↑ at 2, CAS1_N↓ at 3, CAS2_N stays 1. BMREQ_N↑ → all strobes released next edge, RAS_N high ≥1 cycle.
- Z80 refresh: BMREQ_N=BRFSH_N=0 for 2 cycles → RAS_N low 2 cycles, both CAS high, MUX=0, timer reloaded (no IREF for the next 56 cycles).
- DMA handshake: DMA_N↓ → BUSRQ_N↓ +1. BUSAK_N↓ → ADDRBUFEN_N↑ +1. DMA_N↑ → BUSRQ_N↑ +1. BUSAK_N↑ → ADDRBUFEN_N↓ +1.
- Internal refresh in BDMA: idle for 3×REF_INTERVAL cycles → 3 IREF pulses (RAS_N low 2 cycles, REFSEL=1) with REFROW 0, 1, 2; REFROW wraps 127 → 0.
- Collision: timer expires on the same edge as a write with BA15=1 → CAS2_N write completes first, IREF starts right after PRE, and an access arriving during IREF waits.

Source files
------------

// File: rtl/mioc_dram_ctrl_pkg.sv
// Shared types and defaults for the MIOC DRAM sequencer and bus arbiter.
// Memory/bus FSM encodings, refresh row width and timing parameter defaults.
package mioc_pkg;

    localparam int REF_INTERVAL_DEF  = 56;
    localparam int PRECHARGE_CYC_DEF = 1;
    localparam int REFROW_W          = 7;
    localparam int PRE_CNT_W         = 4;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        CAS,
        PRE,
        RFSH,
        IREF
    } mem_state_t;

    typedef enum logic [1:0] {
        BZ80,
        BREQ,
        BDMA,
        BREL
    } bus_state_t;

endpackage

// File: rtl/mioc_dram_ctrl_if.sv
// Buffered Z80 bus, DMA handshake and DRAM strobe signals of the MIOC DRAM controller.
// The slave side is the controller; the master side is the decode/bus logic driving it.
interface mioc_dram_ctrl_if;
    import mioc_pkg::*;

    logic                BMREQ_N;
    logic                BRD_N;
    logic                N_BWR;
    logic                BRFSH_N;
    logic                BA15;
    logic                RAMSEL;
    logic                DMA_N;
    logic                BUSAK_N;
    logic                BUSRQ_N;
    logic                ADDRBUFEN_N;
    logic                RAS_N;
    logic                CAS1_N;
    logic                CAS2_N;
    logic                MUX;
    logic                REFSEL;
    logic [REFROW_W-1:0] REFROW;

    modport master (
        output BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, RAMSEL, DMA_N, BUSAK_N,
        input  BUSRQ_N, ADDRBUFEN_N, RAS_N, CAS1_N, CAS2_N, MUX, REFSEL, REFROW
    );

    modport slave (
        input  BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, RAMSEL, DMA_N, BUSAK_N,
        output BUSRQ_N, ADDRBUFEN_N, RAS_N, CAS1_N, CAS2_N, MUX, REFSEL, REFROW
    );

endinterface

// File: rtl/mioc_dram_ctrl_refresh_timer.sv
// Refresh interval timer with sticky pending flag and the internal refresh row counter.
// 'clear' reloads the interval whenever any refresh starts; 'advance' steps the row.
module mioc_refresh_timer
    import mioc_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic                pending,
    output logic [REFROW_W-1:0] refrow
);

    localparam logic [6:0]          RELOAD  = 7'(REF_INTERVAL - 1);
    localparam logic [REFROW_W-1:0] ROW_ONE = REFROW_W'(1);

    logic [6:0] count;

    // Expiry reloads the counter so it keeps running; pending stays set until a refresh is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= RELOAD;
            pending <= 1'b0;
            refrow  <= '0;
        end else begin
            if (clear) begin
                count   <= RELOAD;
                pending <= 1'b0;
            end else if (count == 7'd0) begin
                count   <= RELOAD;
                pending <= 1'b1;
            end else begin
                count <= count - 7'd1;
            end
            if (advance) begin
                refrow <= refrow + ROW_ONE;
            end
        end
    end

endmodule

// File: rtl/mioc_dram_ctrl.sv
// DRAM access sequencer (RAS/MUX/CAS) with Z80 and internal refresh, plus the
// BUSRQ/BUSAK arbiter that hands the buffered bus to the 6801 DMA master.
module mioc_dram_ctrl
    import mioc_pkg::*;
#(
    parameter int REF_INTERVAL  = REF_INTERVAL_DEF,
    parameter int PRECHARGE_CYC = PRECHARGE_CYC_DEF
) (
    input logic             B_PHI,
    input logic             RST_N,
    mioc_dram_ctrl_if.slave bus
);

    localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRECHARGE_CYC - 1);

    mem_state_t           mem_state;
    bus_state_t           bus_state;
    logic                 bank;
    logic                 ref_owed;
    logic                 iref_second;
    logic [PRE_CNT_W-1:0] pre_cnt;
    logic                 ref_pending;
    logic [REFROW_W-1:0]  refrow;
    logic                 ras_n, cas1_n, cas2_n, mux, refsel;
    logic                 busrq_n, addrbufen_n;

    logic z80_refresh, access_req, take_rfsh, take_iref, take_access;
    logic timer_clear, row_advance;

    assign z80_refresh = !bus.BMREQ_N && !bus.BRFSH_N;
    assign access_req  = !bus.BMREQ_N && bus.BRFSH_N && bus.RAMSEL && (!bus.BRD_N || !bus.N_BWR);

    // An owed refresh (one that already sat out an access) outranks the next access.
    assign take_rfsh   = (mem_state == IDLE) && z80_refresh;
    assign take_iref   = (mem_state == IDLE) && !z80_refresh && ref_pending && (ref_owed || !access_req);
    assign take_access = (mem_state == IDLE) && access_req && !take_iref;
    assign timer_clear = take_rfsh || take_iref;
    assign row_advance = (mem_state == IREF) && iref_second;

    mioc_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .clk    (B_PHI),
        .rst_n  (RST_N),
        .clear  (timer_clear),
        .advance(row_advance),
        .pending(ref_pending),
        .refrow (refrow)
    );

    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            mem_state   <= IDLE;
            ras_n       <= 1'b1;
            cas1_n      <= 1'b1;
            cas2_n      <= 1'b1;
            mux         <= 1'b0;
            refsel      <= 1'b0;
            bank        <= 1'b0;
            ref_owed    <= 1'b0;
            iref_second <= 1'b0;
            pre_cnt     <= '0;
        end else begin
            if (mem_state != IDLE && ref_pending) begin
                ref_owed <= 1'b1;
            end
            case (mem_state)
                IDLE: begin
                    if (take_rfsh) begin
                        mem_state <= RFSH;
                        ras_n     <= 1'b0;
                        ref_owed  <= 1'b0;
                    end else if (take_iref) begin
                        mem_state   <= IREF;
                        ras_n       <= 1'b0;
                        refsel      <= 1'b1;
                        iref_second <= 1'b0;
                        ref_owed    <= 1'b0;
                    end else if (take_access) begin
                        mem_state <= ROW;
                        ras_n     <= 1'b0;
                        bank      <= bus.BA15;
                    end
                end
                // A request dropped before CAS aborts straight to precharge.
                ROW, COL, CAS, RFSH: begin
                    if (bus.BMREQ_N) begin
                        mem_state <= PRE;
                        ras_n     <= 1'b1;
                        cas1_n    <= 1'b1;
                        cas2_n    <= 1'b1;
                        mux       <= 1'b0;
                        pre_cnt   <= PRE_LAST;
                    end else if (mem_state == ROW) begin
                        mem_state <= COL;
                        mux       <= 1'b1;
                    end else if (mem_state == COL) begin
                        mem_state <= CAS;
                        cas1_n    <= bank;
                        cas2_n    <= !bank;
                    end
                end
                IREF: begin
                    if (iref_second) begin
                        mem_state <= PRE;
                        ras_n     <= 1'b1;
                        refsel    <= 1'b0;
                        pre_cnt   <= PRE_LAST;
                    end else begin
                        iref_second <= 1'b1;
                    end
                end
                PRE: begin
                    if (pre_cnt == '0) begin
                        mem_state <= IDLE;
                    end else begin
                        pre_cnt <= pre_cnt - PRE_CNT_W'(1);
                    end
                end
                default: mem_state <= IDLE;
            endcase
        end
    end

    // Release back to the Z80 only once the DRAM side is quiet.
    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            bus_state   <= BZ80;
            busrq_n     <= 1'b1;
            addrbufen_n <= 1'b0;
        end else begin
            case (bus_state)
                BZ80: begin
                    if (!bus.DMA_N) begin
                        bus_state <= BREQ;
                        busrq_n   <= 1'b0;
                    end
                end
                BREQ: begin
                    if (!bus.BUSAK_N) begin
                        bus_state   <= BDMA;
                        addrbufen_n <= 1'b1;
                    end else if (bus.DMA_N) begin
                        bus_state <= BZ80;
                        busrq_n   <= 1'b1;
                    end
                end
                BDMA: begin
                    if (bus.DMA_N) begin
                        bus_state <= BREL;
                        busrq_n   <= 1'b1;
                    end
                end
                BREL: begin
                    if (bus.BUSAK_N && mem_state == IDLE) begin
                        bus_state   <= BZ80;
                        addrbufen_n <= 1'b0;
                    end
                end
                default: bus_state <= BZ80;
            endcase
        end
    end

    assign bus.RAS_N       = ras_n;
    assign bus.CAS1_N      = cas1_n;
    assign bus.CAS2_N      = cas2_n;
    assign bus.MUX         = mux;
    assign bus.REFSEL      = refsel;
    assign bus.REFROW      = refrow;
    assign bus.BUSRQ_N     = busrq_n;
    assign bus.ADDRBUFEN_N = addrbufen_n;

endmodule

// File: tb/tb_mioc_dram_ctrl.sv
// Directed bench for mioc_dram_ctrl: a vector table for single-cycle behaviour plus
// hand sequences for refresh timing, DMA-time refresh, row wrap and the access/refresh collision.
module tb_mioc_dram_ctrl;

    localparam int         REF_INTERVAL = 56;
    // stim = {BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, RAMSEL, DMA_N, BUSAK_N}
    // outs = {RAS_N, CAS1_N, CAS2_N, MUX, REFSEL, BUSRQ_N, ADDRBUFEN_N}
    localparam logic [7:0] IN_IDLE   = 8'b1111_0111;
    localparam logic [7:0] IN_RD     = 8'b0011_0111;
    localparam logic [7:0] IN_WR_B1  = 8'b0101_1111;
    localparam logic [7:0] IN_ZREF   = 8'b0110_0111;
    localparam logic [7:0] IN_DMA    = 8'b1111_0100;
    localparam logic [7:0] IN_ALL    = 8'b0000_1100;
    localparam logic [6:0] OUT_IDLE  = 7'b111_0010;

    typedef struct {
        string      name;
        logic [7:0] stim;
        logic [6:0] exp_out;
    } vec_t;

    logic B_PHI = 1'b0;
    logic RST_N = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   strobe_violations = 0;
    vec_t vecs[$];

    mioc_dram_ctrl_if bus();

    mioc_dram_ctrl #(
        .REF_INTERVAL (REF_INTERVAL),
        .PRECHARGE_CYC(1)
    ) dut (
        .B_PHI(B_PHI),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 B_PHI = ~B_PHI;

    // CAS banks must never overlap and CAS must never be low without RAS.
    always @(negedge B_PHI) begin
        if (RST_N) begin
            if ((!bus.CAS1_N && !bus.CAS2_N) || ((!bus.CAS1_N || !bus.CAS2_N) && bus.RAS_N))
                strobe_violations++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] outs();
        return {bus.RAS_N, bus.CAS1_N, bus.CAS2_N, bus.MUX, bus.REFSEL, bus.BUSRQ_N, bus.ADDRBUFEN_N};
    endfunction

    task automatic applyStimulus(input logic [7:0] s);
        bus.BMREQ_N = s[7];
        bus.BRD_N   = s[6];
        bus.N_BWR   = s[5];
        bus.BRFSH_N = s[4];
        bus.BA15    = s[3];
        bus.RAMSEL  = s[2];
        bus.DMA_N   = s[1];
        bus.BUSAK_N = s[0];
    endtask

    task automatic tick();
        @(posedge B_PHI);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
        end
    endtask

    task automatic stepCheck(input string name, input logic [7:0] s, input logic [6:0] e);
        applyStimulus(s);
        tick();
        checkOutput(name, {1'b0, outs()}, {1'b0, e});
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        applyStimulus(IN_ALL);
        repeat (3) tick();
        checkOutput("reset_outs", {1'b0, outs()}, {1'b0, OUT_IDLE});
        checkOutput("reset_refrow", {1'b0, bus.REFROW}, 8'd0);
        RST_N = 1'b1;
        applyStimulus(IN_IDLE);
    endtask

    task automatic waitIref(input logic [7:0] s, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            applyStimulus(s);
            tick();
            if (!bus.RAS_N) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int lows;

        vecs.push_back('{"rd_row",        IN_RD,        7'b011_0010});
        vecs.push_back('{"rd_col",        IN_RD,        7'b011_1010});
        vecs.push_back('{"rd_cas1",       IN_RD,        7'b001_1010});
        vecs.push_back('{"rd_hold",       IN_RD,        7'b001_1010});
        vecs.push_back('{"rd_release",    IN_IDLE,      7'b111_0010});
        vecs.push_back('{"rd_pre",        IN_IDLE,      7'b111_0010});
        vecs.push_back('{"wr_row",        IN_WR_B1,     7'b011_0010});
        vecs.push_back('{"wr_col_ba15",   8'b0101_0111, 7'b011_1010});
        vecs.push_back('{"wr_cas2",       8'b0101_0111, 7'b010_1010});
        vecs.push_back('{"wr_release",    IN_IDLE,      7'b111_0010});
        vecs.push_back('{"wr_pre",        IN_IDLE,      7'b111_0010});
        vecs.push_back('{"drop_row_ras",  IN_RD,        7'b011_0010});
        vecs.push_back('{"drop_row_pre",  IN_IDLE,      7'b111_0010});
        vecs.push_back('{"drop_row_idle", IN_IDLE,      7'b111_0010});
        vecs.push_back('{"drop_row_nocas",IN_IDLE,      7'b111_0010});
        vecs.push_back('{"drop_col_ras",  IN_RD,        7'b011_0010});
        vecs.push_back('{"drop_col_mux",  IN_RD,        7'b011_1010});
        vecs.push_back('{"drop_col_pre",  IN_IDLE,      7'b111_0010});
        vecs.push_back('{"drop_col_idle", IN_IDLE,      7'b111_0010});
        vecs.push_back('{"no_ramsel",     8'b0011_0011, 7'b111_0010});
        vecs.push_back('{"no_ramsel_end", IN_IDLE,      7'b111_0010});
        vecs.push_back('{"zref_ras0",     IN_ZREF,      7'b011_0010});
        vecs.push_back('{"zref_ras1",     IN_ZREF,      7'b011_0010});
        vecs.push_back('{"zref_release",  IN_IDLE,      7'b111_0010});
        vecs.push_back('{"zref_idle",     IN_IDLE,      7'b111_0010});
        vecs.push_back('{"dma_busrq",     8'b1111_0101, 7'b111_0000});
        vecs.push_back('{"dma_bufoff",    IN_DMA,       7'b111_0001});
        vecs.push_back('{"dma_hold",      IN_DMA,       7'b111_0001});
        vecs.push_back('{"dma_busrq_off", 8'b1111_0110, 7'b111_0011});
        vecs.push_back('{"dma_brel_hold", 8'b1111_0110, 7'b111_0011});
        vecs.push_back('{"dma_bufon",     IN_IDLE,      7'b111_0010});
        vecs.push_back('{"breq_req",      8'b1111_0101, 7'b111_0000});
        vecs.push_back('{"breq_abort",    IN_IDLE,      7'b111_0010});

        doReset();
        foreach (vecs[i]) stepCheck(vecs[i].name, vecs[i].stim, vecs[i].exp_out);

        // Z80 refresh reloads the interval: nothing internal for the next REF_INTERVAL cycles.
        doReset();
        stepCheck("zt_ras0", IN_ZREF, 7'b011_0010);
        stepCheck("zt_ras1", IN_ZREF, 7'b011_0010);
        stepCheck("zt_release", IN_IDLE, 7'b111_0010);
        lows = 0;
        for (int i = 0; i < REF_INTERVAL - 2; i++) begin
            applyStimulus(IN_IDLE);
            tick();
            if (!bus.RAS_N || bus.REFSEL) lows++;
        end
        checkOutput("zt_no_iref", 8'(lows), 8'd0);
        waitIref(IN_IDLE, 8, seen);
        checkOutput("zt_iref_later", {7'd0, seen}, 8'd1);
        checkOutput("zt_iref_refsel", {7'd0, bus.REFSEL}, 8'd1);

        // Internal refreshes while the 6801 owns the bus, through the row wrap.
        doReset();
        stepCheck("bd_busrq", 8'b1111_0101, 7'b111_0000);
        stepCheck("bd_grant", IN_DMA, 7'b111_0001);
        for (int p = 0; p < 128; p++) begin
            waitIref(IN_DMA, REF_INTERVAL + 8, seen);
            checkOutput($sformatf("bd_iref%0d_seen", p), {7'd0, seen}, 8'd1);
            if (!seen) break;
            if (p < 3 || p == 127) begin
                checkOutput($sformatf("bd_iref%0d_c1", p), {1'b0, outs()}, {1'b0, 7'b011_0101});
                checkOutput($sformatf("bd_iref%0d_row", p), {1'b0, bus.REFROW}, {1'b0, 7'(p)});
                stepCheck($sformatf("bd_iref%0d_c2", p), IN_DMA, 7'b011_0101);
                stepCheck($sformatf("bd_iref%0d_pre", p), IN_DMA, 7'b111_0001);
                checkOutput($sformatf("bd_iref%0d_next", p), {1'b0, bus.REFROW}, {1'b0, 7'((p + 1) % 128)});
            end else begin
                applyStimulus(IN_DMA);
                repeat (2) tick();
            end
        end

        // Timer expires on the edge a bank-2 write starts.
        doReset();
        lows = 0;
        for (int i = 0; i < REF_INTERVAL - 1; i++) begin
            applyStimulus(IN_IDLE);
            tick();
            if (!bus.RAS_N) lows++;
        end
        checkOutput("coll_quiet", 8'(lows), 8'd0);
        stepCheck("coll_row",        IN_WR_B1, 7'b011_0010);
        stepCheck("coll_col",        IN_WR_B1, 7'b011_1010);
        stepCheck("coll_cas2",       IN_WR_B1, 7'b010_1010);
        stepCheck("coll_hold",       IN_WR_B1, 7'b010_1010);
        stepCheck("coll_pre",        IN_IDLE,  7'b111_0010);
        stepCheck("coll_idle",       IN_IDLE,  7'b111_0010);
        stepCheck("coll_iref1",      IN_IDLE,  7'b011_0110);
        stepCheck("coll_iref2_wait", IN_RD,    7'b011_0110);
        stepCheck("coll_iref_pre",   IN_RD,    7'b111_0010);
        stepCheck("coll_idle2",      IN_RD,    7'b111_0010);
        stepCheck("coll_rd_row",     IN_RD,    7'b011_0010);
        stepCheck("coll_rd_col",     IN_RD,    7'b011_1010);
        stepCheck("coll_rd_cas1",    IN_RD,    7'b001_1010);
        checkOutput("coll_refrow", {1'b0, bus.REFROW}, 8'd1);

        // Reset in the middle of a CAS cycle drops every strobe on the next edge.
        RST_N = 1'b0;
        applyStimulus(IN_RD);
        tick();
        checkOutput("midreset_outs", {1'b0, outs()}, {1'b0, OUT_IDLE});
        checkOutput("midreset_refrow", {1'b0, bus.REFROW}, 8'd0);
        RST_N = 1'b1;
        applyStimulus(IN_IDLE);
        tick();

        checkOutput("strobe_rules", 8'(strobe_violations), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
